adder_tree_accum: RTL
=====================

Name: adder_tree_accum

Overview:
- Downstream consumer of the 3-level adder tree top.
- Takes the registered tree sum (ADDER_WIDTH+1 bits, one new value per valid cycle) and accumulates ACC_COUNT consecutive sums into one block total.
- Presents each block total on a valid/ready output slot for the next datapath stage.
- Input side has no backpressure because the tree is a free-running pipeline; output conflicts are flagged, not stalled.

Parameters:
- ADDER_WIDTH, 20, operand width of the adder tree leaves.
- IN_WIDTH, ADDER_WIDTH+1, width of the tree sum consumed here.
- ACC_COUNT, 16, sums per block; power of two, range 2..256.
- ACC_WIDTH, IN_WIDTH+$clog2(ACC_COUNT), accumulator/result width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock shared with the adder tree.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of the partial block.
- in_valid  in  1  in_sum carries a new tree result this cycle.
- in_sum  in  IN_WIDTH  unsigned tree sum.
- out_valid  out  1  out_data holds an unconsumed block total.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  ACC_WIDTH  block total (or mean, see Optional Feature).
- sample_cnt  out  $clog2(ACC_COUNT)  samples accumulated in the current partial block.
- overrun  out  1  sticky: a completed block was dropped.

Behaviour:
- Reset (rst high, async assert):
  - acc, sample_cnt, out_data, out_valid, overrun = 0.
  - FSM = IDLE.
  - Deassertion is used synchronously.
- Accumulator FSM:
  - IDLE: sample_cnt=0, acc=0. in_valid -> acc=in_sum, sample_cnt=1, go ACCUM.
  - ACCUM: in_valid with sample_cnt<ACC_COUNT-1 -> acc+=in_sum, sample_cnt+=1.
  - ACCUM: in_valid with sample_cnt==ACC_COUNT-1 -> block complete; acc=0, sample_cnt=0, go IDLE.
  - in_valid low -> hold state, acc and sample_cnt.
- Arithmetic:
  - Unsigned, zero-extended to ACC_WIDTH.
  - Overflow is impossible by construction. Example: 16 × 0x1FFFFF = 0x1FFFFF0 fits in 25 bits.
- Output slot, two states, EMPTY/FULL, independent of the accumulator FSM:
  - On block completion, the final value acc+in_sum is loaded into out_data when the slot is EMPTY, or FULL with out_ready=1 in the same cycle. out_valid=1 the next cycle (latency 1 from the last accepted sample).
  - Completion while the slot is FULL and out_ready=0: the new total is dropped, overrun<=1, the held out_data is unchanged.
  - out_valid && out_ready with no completion -> out_valid<=0; out_data holds its last value.
  - out_data is stable while out_valid=1 and out_ready=0.
- clear:
  - Forces acc=0, sample_cnt=0, FSM=IDLE.
  - clear and in_valid in the same cycle: clear wins, the sample is discarded, no completion.
  - clear does not touch the output slot or overrun.
- overrun: cleared only by rst.
- rst mid-block or with a pending output: everything is discarded immediately, no out_valid afterwards.
- Back-to-back completions every ACC_COUNT cycles with out_ready tied high: no loss, no overrun.

Optional Feature:
- Macro: ADDER_TREE_ACCUM_MEAN_EN.
- Defined:
  - out_data = block total >> $clog2(ACC_COUNT), i.e. truncating mean, zero-extended to ACC_WIDTH.
  - Upper $clog2(ACC_COUNT) bits of out_data are always 0.
- Undefined: out_data = full block total.
- Timing, handshake and overrun rules are identical in both builds.

Decomposition:
- Package adder_tree_pkg holds:
  - ADDER_WIDTH default.
  - Width helper functions (in/acc width from ADDER_WIDTH, tree levels and ACC_COUNT).
  - typedef enum logic {IDLE, ACCUM} accum_state_t.
  - typedef enum logic {EMPTY, FULL} slot_state_t.
- One sub-module is natural: adder_tree_out_slot, a single-entry valid/ready holding register with drop-and-flag on full. It is reusable after other tree stages.

Test Plan:
- 16 × in_sum=1, in_valid every cycle, out_ready=1 -> one out_valid pulse one cycle after the 16th sample, out_data=16 (mean build: 1).
- 16 × in_sum=0x1FFFFF -> out_data=0x1FFFFF0 (mean build: 0x1FFFFF); overrun=0.
- 5 samples of 7, then clear, then 16 samples of 2 -> out_data=32; sample_cnt reads 5 before clear and 0 after.
- out_ready=0 through two full blocks (values 3, then 4) -> out_data stays 48, overrun=1 after the second block. Then out_ready=1 -> one transfer of 48, out_valid drops.
- in_valid gapped (every third cycle), 16 samples of 10 -> out_data=160; sample_cnt holds across gaps.
- rst pulsed with sample_cnt=9 and out_valid=1 -> all outputs 0 at once; next 16 samples of 1 -> out_data=16.

Source files
------------

// File: rtl/adder_tree_accum_pkg.sv
// adder_tree_pkg: shared types, defaults and width helpers for the adder
// tree accumulator slice.
//   calc_in_width  : width of the registered tree sum for a given leaf width
//   calc_cnt_width : width of the in-block sample counter
//   calc_acc_width : accumulator / block-total width (no overflow possible)
package adder_tree_pkg;

  localparam int ADDER_WIDTH_DEF = 20;

  typedef enum logic {IDLE, ACCUM} accum_state_t;
  typedef enum logic {EMPTY, FULL} slot_state_t;

  function automatic int calc_in_width(input int adder_width);
    return adder_width + 1;
  endfunction

  function automatic int calc_cnt_width(input int acc_count);
    return $clog2(acc_count);
  endfunction

  // Summing acc_count values of in_width bits needs log2(acc_count) extra
  // bits when acc_count is a power of two.
  function automatic int calc_acc_width(input int in_width, input int acc_count);
    return in_width + $clog2(acc_count);
  endfunction

endpackage

// File: rtl/adder_tree_accum_if.sv
// adder_tree_accum_if: stream bundle between the adder tree, the accumulator
// and the next datapath stage.
//   clear      : synchronous flush of the partial block
//   in_valid   : in_sum carries a new tree result
//   in_sum     : unsigned tree sum (IN_WIDTH)
//   out_valid  : out_data holds an unconsumed block total
//   out_ready  : downstream accepts out_data
//   out_data   : block total or mean (ACC_WIDTH)
//   sample_cnt : samples in the current partial block (CNT_WIDTH)
//   overrun    : sticky flag, a completed block was dropped
// master = producer/consumer environment, slave = accumulator.
interface adder_tree_accum_if
  import adder_tree_pkg::*;
#(
  parameter int IN_WIDTH  = calc_in_width(ADDER_WIDTH_DEF),
  parameter int ACC_WIDTH = calc_acc_width(IN_WIDTH, 16),
  parameter int CNT_WIDTH = calc_cnt_width(16)
);

  logic                 clear;
  logic                 in_valid;
  logic [IN_WIDTH-1:0]  in_sum;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0] sample_cnt;
  logic                 overrun;

  modport master (
    output clear, in_valid, in_sum, out_ready,
    input  out_valid, out_data, sample_cnt, overrun
  );

  modport slave (
    input  clear, in_valid, in_sum, out_ready,
    output out_valid, out_data, sample_cnt, overrun
  );

endinterface

// File: rtl/adder_tree_accum_out_slot.sv
// adder_tree_out_slot: single-entry valid/ready holding register.
// A load is accepted when the slot is empty or is being drained in the same
// cycle; a load into a full, stalled slot is dropped and raises a sticky
// overrun flag (cleared only by rst). Held data never changes while full.
//   clk, rst   : clock, async active-high reset
//   load_i     : new value presented on data_i
//   data_i     : value to hold
//   ready_i    : downstream accepts data_o this cycle
//   valid_o    : data_o is unconsumed
//   data_o     : held value
//   overrun_o  : sticky drop flag
module adder_tree_out_slot
  import adder_tree_pkg::*;
#(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             overrun_o
);

  slot_state_t      state_q;
  logic [WIDTH-1:0] data_q;
  logic             overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (load_i) begin
            data_q  <= data_i;
            state_q <= FULL;
          end
        end
        FULL: begin
          if (load_i) begin
            if (ready_i) begin
              // drain and refill in the same cycle keeps the slot full
              data_q <= data_i;
            end else begin
              overrun_q <= 1'b1;
            end
          end else if (ready_i) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign valid_o   = (state_q == FULL);
  assign data_o    = data_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/adder_tree_accum.sv
// adder_tree_accum: accumulates ACC_COUNT consecutive adder-tree sums into a
// block total and hands it to the next stage through a one-entry output slot.
// The input side never stalls; a block completing into a stalled full slot
// is dropped and flagged on overrun.
//   clk  : rising-edge clock shared with the adder tree
//   rst  : asynchronous active-high reset
//   bus  : adder_tree_accum_if.slave (clear, in_valid/in_sum,
//          out_valid/out_ready/out_data, sample_cnt, overrun)
// ACC_COUNT must be a power of two in 2..256.
// Optional build macro ADDER_TREE_ACCUM_MEAN_EN: when defined, out_data is the
// truncating mean (block total >> log2(ACC_COUNT)) instead of the total.
//
// state | meaning
// IDLE  | no samples in the current block, acc and count are zero
// ACCUM | 1..ACC_COUNT-1 samples accumulated
module adder_tree_accum
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
  parameter int IN_WIDTH    = calc_in_width(ADDER_WIDTH),
  parameter int ACC_COUNT   = 16
) (
  input logic                clk,
  input logic                rst,
  adder_tree_accum_if.slave  bus
);

  localparam int ACC_WIDTH = calc_acc_width(IN_WIDTH, ACC_COUNT);
  localparam int CNT_WIDTH = calc_cnt_width(ACC_COUNT);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ACC_COUNT - 1);

  accum_state_t         state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic                 accept;
  logic                 complete;
  logic [ACC_WIDTH-1:0] block_total_d;
  logic [ACC_WIDTH-1:0] slot_data_d;

  logic                 slot_valid;
  logic [ACC_WIDTH-1:0] slot_data;
  logic                 slot_overrun;

  // clear has priority: a sample arriving with clear is discarded
  assign accept        = bus.in_valid && !bus.clear;
  assign complete      = accept && (state_q == ACCUM) && (cnt_q == LAST_CNT);
  assign block_total_d = acc_q + ACC_WIDTH'(bus.in_sum);

`ifdef ADDER_TREE_ACCUM_MEAN_EN
  assign slot_data_d = block_total_d >> CNT_WIDTH;
`else
  assign slot_data_d = block_total_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (bus.clear) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (bus.in_valid) begin
      case (state_q)
        IDLE: begin
          acc_q   <= ACC_WIDTH'(bus.in_sum);
          cnt_q   <= CNT_WIDTH'(1);
          state_q <= ACCUM;
        end
        ACCUM: begin
          if (cnt_q == LAST_CNT) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            acc_q <= block_total_d;
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  adder_tree_out_slot #(
    .WIDTH (ACC_WIDTH)
  ) u_out_slot (
    .clk       (clk),
    .rst       (rst),
    .load_i    (complete),
    .data_i    (slot_data_d),
    .ready_i   (bus.out_ready),
    .valid_o   (slot_valid),
    .data_o    (slot_data),
    .overrun_o (slot_overrun)
  );

  assign bus.out_valid  = slot_valid;
  assign bus.out_data   = slot_data;
  assign bus.overrun    = slot_overrun;
  assign bus.sample_cnt = cnt_q;

endmodule
